spi_write_sequencer: RTL and testbench



---
 rtl/spi_regs_pkg.sv | 23 ++
 rtl/spi_cmd_fifo.sv | 49 ++++
 rtl/spi_write_sequencer.sv | 135 +++++++++++++
 tb/tb_spi_write_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_regs_pkg.sv
// Shared constants for the SPI register-file write path:
// frame layout, peripheral register map and sequencer states.
package spi_regs_pkg;

   localparam int FRAME_W   = 16;
   localparam int WRITE_BIT = 15;

   localparam logic [6:0] REG_EN_OUT_7_0  = 7'h00;
   localparam logic [6:0] REG_EN_OUT_15_8 = 7'h01;
   localparam logic [6:0] REG_EN_PWM_7_0  = 7'h02;
   localparam logic [6:0] REG_EN_PWM_15_8 = 7'h03;
   localparam logic [6:0] REG_PWM_DUTY    = 7'h04;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEAD,
      ST_HIGH,
      ST_LOW,
      ST_TRAIL,
      ST_GAP
   } state_t;

endpackage

// File: rtl/spi_cmd_fifo.sv
// Command FIFO: registered storage, count-based full/empty,
// simultaneous push and pop both honoured.
module spi_cmd_fifo #(
   parameter int WIDTH = 15,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/spi_write_sequencer.sv
// Turns queued register writes into SPI mode-0 write frames.
// Pin outputs are registered from the current state (one cycle behind).
module spi_write_sequencer
   import spi_regs_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int CS_GAP     = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [6:0] cmd_addr,
   input  logic [7:0] cmd_data,
   output logic       sclk,
   output logic       copi,
   output logic       ncs,
   output logic       busy,
   output logic       frame_done
);

   localparam int CMAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
   localparam int CW   = $clog2(CMAX);
   localparam logic [CW-1:0] DIV_LD = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] GAP_LD = CW'(CS_GAP - 1);

   state_t               state, state_d;
   logic [CW-1:0]        cnt, cnt_d;
   logic [3:0]           bitcnt, bit_d;
   logic [FRAME_W-1:0]   sh, sh_d;
   logic [14:0]          fifo_rdata;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 pop;
   logic                 active;

   spi_cmd_fifo #(
      .WIDTH (15),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cmd_valid && cmd_ready),
      .wdata ({cmd_addr, cmd_data}),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign cmd_ready = !fifo_full;
   assign busy      = !fifo_empty || (state != ST_IDLE);
   assign active    = (state != ST_IDLE) && (state != ST_GAP);

   always_comb begin
      state_d = state;
      cnt_d   = cnt - 1'b1;
      bit_d   = bitcnt;
      sh_d    = sh;
      pop     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            cnt_d = cnt;
            if (!fifo_empty) begin
               pop     = 1'b1;
               sh_d    = {1'b1, fifo_rdata};
               bit_d   = 4'd15;
               cnt_d   = DIV_LD;
               state_d = ST_LEAD;
            end
         end
         ST_LEAD: if (cnt == '0) begin
            cnt_d   = DIV_LD;
            state_d = ST_HIGH;
         end
         ST_HIGH: if (cnt == '0) begin
            cnt_d = DIV_LD;
            if (bitcnt == '0) begin
               state_d = ST_TRAIL;
            end else begin
               bit_d   = bitcnt - 1'b1;
               sh_d    = {sh[FRAME_W-2:0], 1'b0};
               state_d = ST_LOW;
            end
         end
         ST_LOW: if (cnt == '0) begin
            cnt_d   = DIV_LD;
            state_d = ST_HIGH;
         end
         ST_TRAIL: if (cnt == '0) begin
            cnt_d   = GAP_LD;
            state_d = ST_GAP;
         end
         ST_GAP: if (cnt == '0) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         bitcnt <= '0;
         sh     <= '0;
      end else begin
         state  <= state_d;
         cnt    <= cnt_d;
         bitcnt <= bit_d;
         sh     <= sh_d;
      end
   end

   // frame_done marks the first GAP cycle, which is when ncs rises
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ncs        <= 1'b1;
         sclk       <= 1'b0;
         copi       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         ncs        <= !active;
         sclk       <= (state == ST_HIGH);
         copi       <= active && sh[WRITE_BIT];
         frame_done <= (state == ST_GAP) && (cnt == GAP_LD);
      end
   end

endmodule

// File: tb/tb_spi_write_sequencer.sv
// Scoreboard bench: accepted commands queue expected frames, a pin
// monitor decodes SPI frames and feeds a peripheral register model.
module tb_spi_write_sequencer;

   localparam int CD = 4;
   localparam int FD = 4;
   localparam int CG = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [6:0] cmd_addr = '0;
   logic [7:0] cmd_data = '0;
   logic       cmd_ready, sclk, copi, ncs, busy, frame_done;

   always #5 clk = ~clk;

   spi_write_sequencer #(
      .CLK_DIV    (CD),
      .FIFO_DEPTH (FD),
      .CS_GAP     (CG)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_addr   (cmd_addr),
      .cmd_data   (cmd_data),
      .sclk       (sclk),
      .copi       (copi),
      .ncs        (ncs),
      .busy       (busy),
      .frame_done (frame_done)
   );

   int checks = 0;
   int failures = 0;
   logic [15:0] exp_q[$];
   logic [7:0]  per_regs[5];
   logic [7:0]  ref_regs[5];

   int          rises, low_cnt, high_cnt;
   bit          have_prev, gap_exact;
   logic [15:0] mon_sh;
   logic        p_ncs, p_sclk, p_copi;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic flag(input string name, input bit ok, input int act);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%0d", name, act);
      end
   endtask

   // pin monitor and peripheral model
   always @(negedge clk) begin
      if (!rst_n) begin
         rises = 0; low_cnt = 0; high_cnt = 0;
         have_prev = 0; gap_exact = 0; mon_sh = '0;
         p_ncs = 1'b1; p_sclk = 1'b0; p_copi = 1'b0;
         for (int i = 0; i < 5; i++) begin
            per_regs[i] = '0;
            ref_regs[i] = '0;
         end
      end else begin
         if (p_ncs && !ncs) begin
            if (have_prev) begin
               if (gap_exact) chk("gap_exact", high_cnt, CG + 1);
               else flag("gap_min", high_cnt >= CG + 1, high_cnt);
            end
            rises = 0; low_cnt = 0; mon_sh = '0;
         end
         if (!ncs) begin
            low_cnt++;
            if (sclk && !p_sclk) begin
               mon_sh = {mon_sh[14:0], copi};
               rises++;
            end
            if (!p_ncs && (copi !== p_copi))
               flag("copi_edge", p_sclk && !sclk, int'(sclk));
         end else if (sclk) begin
            flag("sclk_idle", 1'b0, int'(sclk));
         end
         if (!p_ncs && ncs) begin
            logic [15:0] e;
            chk("sclk_rises", rises, 16);
            chk("ncs_low", low_cnt, 33 * CD);
            chk("frame_done", frame_done, 1);
            if (exp_q.size() == 0) begin
               flag("unexpected_frame", 1'b0, int'(mon_sh));
            end else begin
               e = exp_q.pop_front();
               chk("frame", mon_sh, e);
               if (e[15] && e[14:8] <= 7'd4) ref_regs[e[10:8]] = e[7:0];
            end
            if (mon_sh[15] && mon_sh[14:8] <= 7'd4)
               per_regs[mon_sh[10:8]] = mon_sh[7:0];
            gap_exact = (exp_q.size() > 0);
            have_prev = 1;
            high_cnt = 1;
         end else begin
            if (ncs) high_cnt++;
            if (frame_done) flag("stray_frame_done", 1'b0, 1);
         end
         p_ncs = ncs; p_sclk = sclk; p_copi = copi;
      end
   end

   task automatic send(input logic [6:0] a, input logic [7:0] d);
      int n = 0;
      bit acc = 0;
      while (!acc && n < 3000) begin
         @(negedge clk);
         cmd_valid = 1'b1; cmd_addr = a; cmd_data = d;
         acc = cmd_ready;
         @(posedge clk);
         if (acc) exp_q.push_back({1'b1, a, d});
         n++;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      if (!acc) flag("send_timeout", 1'b0, n);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || !ncs) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20000) flag("idle_timeout", 1'b0, n);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n8, i, cyc, n;
      logic [7:0] vals [4];
      vals[0] = 8'hA5; vals[1] = 8'h5A; vals[2] = 8'hFF; vals[3] = 8'h01;

      repeat (3) @(negedge clk);
      chk("rst_ncs", ncs, 1);
      chk("rst_sclk", sclk, 0);
      chk("rst_copi", copi, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", cmd_ready, 1);
      #2 rst_n = 1'b1;
      repeat (2) @(negedge clk);

      send(7'h04, 8'h80);
      chk("busy_after_accept", busy, 1);
      @(negedge clk);
      chk("lat_ncs_n1", ncs, 1);
      @(negedge clk);
      chk("lat_ncs_n2", ncs, 0);
      wait_idle();
      chk("pwm_duty", per_regs[4], 8'h80);

      // reset in the middle of a frame
      send(7'h00, 8'hFF);
      n = 0;
      while (n < 2000) begin
         @(negedge clk); #1;
         if (rises >= 8) break;
         n++;
      end
      flag("reach_8_rises", rises >= 8, rises);
      #2 rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("rst_mid_ncs", ncs, 1);
      chk("rst_mid_sclk", sclk, 0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_ready", cmd_ready, 1);
      repeat (300) @(negedge clk);
      chk("post_rst_en0", per_regs[0], 8'h00);
      chk("post_rst_ncs", ncs, 1);

      for (int k = 0; k < 4; k++) send(7'(k), vals[k]);
      wait_idle();
      for (int k = 0; k < 4; k++) chk("en_reg", per_regs[k], vals[k]);

      send(7'h05, 8'h33);
      wait_idle();
      for (int k = 0; k < 4; k++) chk("unchanged", per_regs[k], vals[k]);
      chk("unchanged_duty", per_regs[4], 8'h00);

      // cmd_valid held for six back-to-back commands
      i = 0; cyc = 0; n8 = 0;
      while (i < 6 && cyc < 3000) begin
         @(negedge clk);
         cmd_valid = 1'b1;
         cmd_addr = 7'(i + 1);
         cmd_data = 8'(8'h10 * i + 3);
         n = int'(cmd_ready);
         @(posedge clk);
         if (n != 0) begin
            exp_q.push_back({1'b1, 7'(i + 1), 8'(8'h10 * i + 3)});
            i++;
         end
         cyc++;
         if (cyc == 8) n8 = i;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("btb_accepted_early", n8, 5);
      chk("btb_all_sent", i, 6);
      wait_idle();

      // push coinciding with the IDLE pop while three entries wait
      send(7'h02, 8'h11);
      send(7'h03, 8'h22);
      send(7'h04, 8'h33);
      send(7'h01, 8'h44);
      n = 0;
      while (n < 2000) begin
         @(negedge clk); #1;
         if (frame_done) break;
         n++;
      end
      flag("frame_done_seen", frame_done, n);
      repeat (CG - 2) @(negedge clk);
      send(7'h00, 8'h55);
      chk("same_cycle_ready", cmd_ready, 1);
      wait_idle();

      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(3) == 0)
            repeat ($urandom_range(150)) @(negedge clk);
         send(7'($urandom_range(7)), 8'($urandom_range(255)));
      end
      wait_idle();

      chk("queue_drained", exp_q.size(), 0);
      for (int k = 0; k < 5; k++) chk("final_reg", per_regs[k], ref_regs[k]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
